// File: rtl/mem_resp_ctrl_if.sv
// Request/response handshake bundle between a processor load/store unit and mem_resp_ctrl.
interface mem_resp_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_resp_ctrl.sv
// Single-outstanding load/store memory with fixed response latency, RISC-V sizes,
// little-endian byte lanes and error responses for bad requests.
module mem_resp_ctrl #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 32
) (
  input  logic            CLK,
  input  logic            RST,
  mem_resp_ctrl_if.slave  bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept, req_err, enter_resp;

  logic            cap_we;
  logic [2:0]      cap_f3;
  logic [AW+2:0]   cap_addr;
  logic [63:0]     cap_wdata;

  logic            op_we, op_err;
  logic [2:0]      op_f3;
  logic [AW+2:0]   op_addr;
  logic [63:0]     op_wdata;

  logic [63:0]     mem [DEPTH];
  logic [63:0]     word, wsh, wmask, rword, ext;
  logic [7:0]      bmask;
  logic [AW-1:0]   idx;
  logic [2:0]      lane;
  logic [63:0]     rdata_q;
  logic            err_q;

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3[1:0])
      2'd1:    req_err = bus.req_addr[0];
      2'd2:    req_err = |bus.req_addr[1:0];
      2'd3:    req_err = |bus.req_addr[2:0];
      default: req_err = 1'b0;
    endcase
    if (bus.req_addr >= MAX_ADDR)            req_err = 1'b1;
    if (bus.req_funct3 == 3'b111)            req_err = 1'b1;
    if (bus.req_we && bus.req_funct3[2])     req_err = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        if (LATENCY > 0 && !req_err) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end else begin
          state_nxt = RESP;
        end
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // RESP can be entered straight from IDLE, so the operation comes from the live request there
  always_comb begin
    if (state == IDLE) begin
      op_we    = bus.req_we;
      op_f3    = bus.req_funct3;
      op_addr  = bus.req_addr[AW+2:0];
      op_wdata = bus.req_wdata;
      op_err   = req_err;
    end else begin
      op_we    = cap_we;
      op_f3    = cap_f3;
      op_addr  = cap_addr;
      op_wdata = cap_wdata;
      op_err   = 1'b0;
    end
  end

  assign lane = op_addr[2:0];
  assign idx  = op_addr[AW+2:3];
  assign word = mem[idx];

  always_comb begin
    case (op_f3[1:0])
      2'd0:    bmask = 8'h01;
      2'd1:    bmask = 8'h03;
      2'd2:    bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
    bmask = bmask << lane;
    for (int i = 0; i < 8; i++) wmask[i*8 +: 8] = {8{bmask[i]}};
    wsh   = op_wdata << {lane, 3'b000};
    rword = word >> {lane, 3'b000};
    case (op_f3)
      3'b000:  ext = {{56{rword[7]}},  rword[7:0]};
      3'b001:  ext = {{48{rword[15]}}, rword[15:0]};
      3'b010:  ext = {{32{rword[31]}}, rword[31:0]};
      3'b011:  ext = rword;
      3'b100:  ext = {56'd0, rword[7:0]};
      3'b101:  ext = {48'd0, rword[15:0]};
      3'b110:  ext = {32'd0, rword[31:0]};
      default: ext = 64'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
      cap_we    <= 1'b0;
      cap_f3    <= 3'd0;
      cap_addr  <= '0;
      cap_wdata <= 64'd0;
      rdata_q   <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_f3    <= bus.req_funct3;
        cap_addr  <= bus.req_addr[AW+2:0];
        cap_wdata <= bus.req_wdata;
      end
      if (enter_resp) begin
        if (op_err) begin
          rdata_q <= 64'd0;
          err_q   <= 1'b1;
        end else if (op_we) begin
          mem[idx] <= (word & ~wmask) | (wsh & wmask);
          rdata_q  <= 64'd0;
          err_q    <= 1'b0;
        end else begin
          rdata_q <= ext;
          err_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed bench for mem_resp_ctrl: one instance at LATENCY=2 and one at LATENCY=0.
module tb_mem_resp_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem_resp_ctrl_if i0 ();
  mem_resp_ctrl_if i1 ();

  mem_resp_ctrl #(.LATENCY(2), .DEPTH(32)) dut0 (.CLK(CLK), .RST(RST), .bus(i0.slave));
  mem_resp_ctrl #(.LATENCY(0), .DEPTH(32)) dut1 (.CLK(CLK), .RST(RST), .bus(i1.slave));

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;

  assign i0.req_valid  = req_valid & ~sel;
  assign i1.req_valid  = req_valid & sel;
  assign i0.rsp_ready  = rsp_ready & ~sel;
  assign i1.rsp_ready  = rsp_ready & sel;
  assign i0.req_we     = req_we;
  assign i1.req_we     = req_we;
  assign i0.req_funct3 = req_funct3;
  assign i1.req_funct3 = req_funct3;
  assign i0.req_addr   = req_addr;
  assign i1.req_addr   = req_addr;
  assign i0.req_wdata  = req_wdata;
  assign i1.req_wdata  = req_wdata;

  logic        rv, rq, re;
  logic [63:0] rd;
  assign rv = sel ? i1.rsp_valid : i0.rsp_valid;
  assign rq = sel ? i1.req_ready : i0.req_ready;
  assign re = sel ? i1.rsp_err   : i0.rsp_err;
  assign rd = sel ? i1.rsp_rdata : i0.rsp_rdata;

  typedef struct { logic [63:0] rdata; logic err; int cyc; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, then check latency, payload, hold under backpressure and release.
  task automatic txn(input bit s, input bit we, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] er, input bit ee, input int hold);
    exp_t e;
    int   n;
    e.rdata = er;
    e.err   = ee;
    e.cyc   = ((ee || s) ? 0 : 2) + 1;
    sb.push_back(e);
    sel = s; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    #0;
    chk("req_ready_idle", 64'(rq), 64'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rv && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    e = sb.pop_front();
    chk("rsp_seen", 64'(rv), 64'd1);
    chk("latency", 64'(n), 64'(e.cyc));
    chk("rdata", rd, e.rdata);
    chk("err", 64'(re), 64'(e.err));
    repeat (hold) begin
      @(posedge CLK); #1;
      chk("hold_valid", 64'(rv), 64'd1);
      chk("hold_rdata", rd, e.rdata);
      chk("hold_err", 64'(re), 64'(e.err));
      chk("hold_req_ready", 64'(rq), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    chk("post_valid", 64'(rv), 64'd0);
    chk("post_req_ready", 64'(rq), 64'd1);
  endtask

  initial begin
    #2;
    chk("rst_valid", 64'(i0.rsp_valid), 64'd0);
    chk("rst_err", 64'(i0.rsp_err), 64'd0);
    chk("rst_rdata", i0.rsp_rdata, 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_req_ready", 64'(i0.req_ready), 64'd1);

    // LATENCY=2 instance
    txn(0, 1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 64'd0, 0, 0);
    txn(0, 0, 3'b011, 64'h10, 64'd0, 64'h0123456789ABCDEF, 0, 0);
    txn(0, 1, 3'b000, 64'h13, 64'hAAAAAAAAAAAAAA80, 64'd0, 0, 0);
    txn(0, 0, 3'b000, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFF80, 0, 0);
    txn(0, 0, 3'b100, 64'h13, 64'd0, 64'h80, 0, 0);
    txn(0, 0, 3'b011, 64'h10, 64'd0, 64'h0123456780ABCDEF, 0, 0);
    txn(0, 0, 3'b010, 64'h22, 64'd0, 64'd0, 1, 0);
    txn(0, 1, 3'b011, 64'h100, 64'hDEADBEEFDEADBEEF, 64'd0, 1, 0);
    txn(0, 0, 3'b011, 64'hF8, 64'd0, 64'd0, 0, 0);
    txn(0, 0, 3'b011, 64'h10, 64'd0, 64'h0123456780ABCDEF, 0, 5);
    txn(0, 0, 3'b010, 64'h10, 64'd0, 64'hFFFFFFFF80ABCDEF, 0, 0);
    txn(0, 0, 3'b110, 64'h14, 64'd0, 64'h01234567, 0, 0);
    txn(0, 0, 3'b001, 64'h12, 64'd0, 64'hFFFFFFFFFFFF80AB, 0, 0);
    txn(0, 0, 3'b101, 64'h12, 64'd0, 64'h80AB, 0, 0);
    txn(0, 0, 3'b111, 64'h10, 64'd0, 64'd0, 1, 0);
    txn(0, 1, 3'b100, 64'h10, 64'h55, 64'd0, 1, 0);
    txn(0, 0, 3'b011, 64'h10, 64'd0, 64'h0123456780ABCDEF, 0, 0);

    // Reset during WAIT of a store must drop it without any response
    sel = 1'b0; req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'h08; req_wdata = 64'hFF;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(i0.rsp_valid), 64'd0);
    chk("mid_rst_rdata", i0.rsp_rdata, 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
      chk("no_stray_valid", 64'(i0.rsp_valid), 64'd0);
    end
    txn(0, 0, 3'b011, 64'h08, 64'd0, 64'd0, 0, 0);

    // LATENCY=0 instance
    txn(1, 1, 3'b001, 64'h06, 64'h000000000000BEEF, 64'd0, 0, 0);
    txn(1, 0, 3'b101, 64'h06, 64'd0, 64'hBEEF, 0, 0);
    txn(1, 0, 3'b001, 64'h06, 64'd0, 64'hFFFFFFFFFFFFBEEF, 0, 2);
    txn(1, 0, 3'b011, 64'h00, 64'd0, 64'hBEEF000000000000, 0, 0);
    txn(1, 0, 3'b001, 64'h07, 64'd0, 64'd0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_resp_ctrl.md
MEM_RESP_CTRL -- requirements
Module: mem_resp_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2: number of wait cycles between request acceptance and response (0..15).
REQ-002 The block SHALL have parameter DEPTH, default 32: number of 64-bit storage words; valid byte address range is 0 .. DEPTH*8-1.
REQ-003 The block SHALL have port CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST  in  1  asynchronous reset, active-low.
REQ-005 The block SHALL have port req_valid  in  1  the processor presents a request.
REQ-006 The block SHALL have port req_ready  out  1  the block can accept a request this cycle.
REQ-007 The block SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3  in  3  RISC-V size code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-009 The block SHALL have port req_addr  in  64  byte address.
REQ-010 The block SHALL have port req_wdata  in  64  store data; the low bytes are used according to size.
REQ-011 The block SHALL have port rsp_valid  out  1  a response is presented.
REQ-012 The block SHALL have port rsp_ready  in  1  the processor accepts the response.
REQ-013 The block SHALL have port rsp_rdata  out  64  load result, already extended to 64 bits.
REQ-014 The block SHALL have port rsp_err  out  1  the request was rejected (misaligned, out of range, or illegal funct3).

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur when req_valid and req_ready are both 1 on a rising edge; at acceptance the block SHALL capture we, funct3, addr and wdata.
REQ-017 On acceptance, the next state SHALL be WAIT if LATENCY>0 and no error is detected, otherwise RESP; the wait counter SHALL load LATENCY-1 and decrement once per cycle in WAIT.
REQ-018 In WAIT, when the counter is 0 the FSM SHALL go to RESP; rsp_valid SHALL first be 1 exactly LATENCY+1 cycles after the acceptance edge.
REQ-019 Errors SHALL skip WAIT: rsp_valid SHALL be 1 on the cycle after acceptance, with rsp_err=1 and rsp_rdata=0.
REQ-020 The following SHALL be errors:
- addr not aligned to the access size (h: addr[0]; w: addr[1:0]; d: addr[2:0]);
- addr >= DEPTH*8;
- funct3=111;
- req_we=1 with funct3[2]=1.
REQ-021 Storage SHALL be little-endian: word index = addr/8, byte lane = addr[2:0].
REQ-022 A store SHALL write only the lanes covered by its size; other bytes of the word SHALL be unchanged.
REQ-023 A store SHALL commit on the edge on which RESP is entered; a store response SHALL have rsp_rdata=0 and rsp_err=0.
REQ-024 A load SHALL sample storage on the edge on which RESP is entered, so it returns any store committed earlier.
REQ-025 Load extension SHALL be: b/h/w sign-extend, bu/hu/wu zero-extend, d passes 64 bits unchanged.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; the FSM SHALL then return to IDLE on that edge.
REQ-027 req_ready SHALL be 1 on the cycle after the response handshake, so back-to-back requests are accepted no faster than one per LATENCY+2 cycles.
REQ-028 An erroneous request SHALL NOT modify storage.
REQ-029 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-030 While RST=0, asynchronously:
- the state SHALL be IDLE and the counter 0;
- rsp_valid=0, rsp_err=0, rsp_rdata=0;
- all storage words SHALL be 0;
- an in-flight store SHALL be dropped.
REQ-031 req_ready SHALL be 1 from the first rising edge after RST returns to 1.
REQ-032 A reset asserted during WAIT or RESP SHALL abort the transaction with no response.

Verification
REQ-033 Doubleword round trip: store d 0x0123456789ABCDEF at addr 0x10 with LATENCY=2, then load d at 0x10 -> rsp_valid 3 cycles after each acceptance, rdata 0x0123456789ABCDEF, err 0.
REQ-034 Sub-word stores and extension: store b 0x80 at 0x13, then:
- load b at 0x13 -> 0xFFFFFFFFFFFFFF80;
- load bu at 0x13 -> 0x80;
- load d at 0x10 -> 0x0123456780ABCDEF.
REQ-035 Errors:
- load w at 0x22 -> err=1, rdata=0, response 1 cycle after acceptance;
- store d at 0x100 with DEPTH=32 -> err=1, storage unchanged.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable throughout; req_ready=0; the next request is accepted the cycle after rsp_ready=1.
REQ-037 Reset mid-store: drive RST low during WAIT of a store of 0xFF to 0x08, then release and load d at 0x08 -> 0x0, with no stray rsp_valid.
REQ-038 LATENCY=0: a load is answered on the cycle after acceptance; store h 0xBEEF at 0x06, then load hu at 0x06 -> 0xBEEF.
